// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue.
//
// Buffers 2-wide fetch packets between fetch and the combinational decoder. The packet is
// carried opaquely; nothing inside it is inspected. The queue is the registered F/D boundary:
// out_data always comes straight from storage, never from in_data.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (clears pointers, occupancy and storage)
//   flush      pipeline flush; blocks push/pop this cycle and empties the queue at the edge
//   in_valid   fetch packet offered
//   in_ready   queue accepts a packet this cycle (independent of in_valid)
//   in_data    fetch packet
//   out_valid  head packet available (independent of out_ready)
//   out_ready  decoder accepts the head packet
//   out_data   head packet
//   count      current occupancy

module fetch_inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PKG_W = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PKG_W-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PKG_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PKG_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (cnt_q == CntW'(DEPTH));
  assign empty = (cnt_q == '0);

  // No pass-through when full: a pop in the same cycle does not free the slot early.
  assign in_ready  = ~full & ~flush;
  assign out_valid = ~empty & ~flush;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign out_data = mem_q[rd_ptr_q];
  assign count    = cnt_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      // Storage is left as-is; only the bookkeeping is reset.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
